onchip_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM between two masters, s0 and s1 (e.g. CPU data master and a DMA). It issues at most one RAM command per cycle and uses round-robin arbitration on conflict. Read results return with a fixed 1-cycle latency, tagged to the requester that issued the read. It sits between the interconnect and the RAM instance and drives the RAM's address, byteenable, chipselect, write and writedata pins.

---
 rtl/onchip_mem_arbiter.sv | 91 +++++++++
 tb/tb_onchip_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Define ONCHIP_ARB_STATS_EN to add saturating per-port grant and conflict counters.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteenable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
`ifdef ONCHIP_ARB_STATS_EN
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict,
`endif
  input  logic [DATA_W-1:0] mem_readdata
);
  logic ready_q, last_q, last_d, pend0_q, pend0_d, pend1_q, pend1_d;
  logic req0, req1, gnt0, gnt1;
  always_comb begin
    req0    = s0_read | s0_write;
    req1    = s1_read | s1_write;
    // last_q holds the most recently granted port; the other one wins a conflict
    gnt0    = ready_q & req0 & (~req1 | last_q);
    gnt1    = ready_q & req1 & (~req0 | ~last_q);
    last_d  = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
    pend0_d = gnt0 & s0_read & ~s0_write;
    pend1_d = gnt1 & s1_read & ~s1_write;
  end
  assign s0_waitrequest   = ~ready_q | (req0 & ~gnt0);
  assign s1_waitrequest   = ~ready_q | (req1 & ~gnt1);
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;
  assign s0_readdatavalid = pend0_q;
  assign s1_readdatavalid = pend1_q;
  assign mem_chipselect   = gnt0 | gnt1;
  assign mem_write        = (gnt0 & s0_write) | (gnt1 & s1_write);
  assign mem_address      = gnt0 ? s0_address : gnt1 ? s1_address : '0;
  assign mem_byteenable   = gnt0 ? s0_byteenable : gnt1 ? s1_byteenable : '0;
  assign mem_writedata    = gnt0 ? s0_writedata : gnt1 ? s1_writedata : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      last_q  <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      last_q  <= last_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
    end
  end
`ifdef ONCHIP_ARB_STATS_EN
  logic [15:0] grant0_q, grant1_q, conflict_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (gnt0 && grant0_q != 16'hFFFF) grant0_q <= grant0_q + 16'd1;
      if (gnt1 && grant1_q != 16'hFFFF) grant1_q <= grant1_q + 16'd1;
      if (ready_q && req0 && req1 && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end
  end
  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: scoreboard bench with a RAM behind the arbiter and a reference model of arbitration and memory contents.
module tb_onchip_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [9:0] s0_address = '0, s1_address = '0;
  logic [3:0] s0_byteenable = '0, s1_byteenable = '0;
  logic s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic [31:0] s0_writedata = '0, s1_writedata = '0;
  logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic [31:0] s0_readdata, s1_readdata;
  logic [9:0] mem_address;
  logic [3:0] mem_byteenable;
  logic mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata = '0;
`ifdef ONCHIP_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q[2][$];
  logic [31:0] ram[1024];
  logic [31:0] shadow[1024];
  int checks = 0, errors = 0, cyc = 0, edges = 0, start = 0;
  bit ref_last = 1'b1;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
`ifdef ONCHIP_ARB_STATS_EN
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict),
`endif
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  // RAM sitting behind the arbiter: byte-masked write, registered read
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++) if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end else if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else if (edges < 2) edges <= edges + 1;
  end

  // Reference model: who should win this cycle, what RAM should see, what a read should return
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q[0].delete();
      q[1].delete();
      ref_last = 1'b1;
    end else begin
      bit r0, r1, rdy, wr, rd;
      int w;
      logic [9:0] a;
      logic [3:0] be;
      logic [31:0] d;
      r0 = s0_read | s0_write;
      r1 = s1_read | s1_write;
      rdy = edges > 0;
      if (!rdy || !(r0 || r1)) w = -1;
      else if (r0 && r1) w = ref_last ? 0 : 1;
      else w = r0 ? 0 : 1;
      chk("s0_waitrequest", {31'b0, s0_waitrequest}, {31'b0, !rdy || (r0 && w != 0)});
      chk("s1_waitrequest", {31'b0, s1_waitrequest}, {31'b0, !rdy || (r1 && w != 1)});
      chk("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, w >= 0});
      if (w >= 0) begin
        a  = w ? s1_address : s0_address;
        be = w ? s1_byteenable : s0_byteenable;
        d  = w ? s1_writedata : s0_writedata;
        wr = w ? s1_write : s0_write;
        rd = w ? s1_read : s0_read;
        chk("mem_address", {22'b0, mem_address}, {22'b0, a});
        chk("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, be});
        chk("mem_writedata", mem_writedata, d);
        chk("mem_write", {31'b0, mem_write}, {31'b0, wr});
        if (wr) begin
          for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end else if (rd) q[w].push_back('{d: shadow[a], c: cyc});
        ref_last = w[0];
      end else begin
        chk("idle_mem_write", {31'b0, mem_write}, 32'd0);
        chk("idle_mem_address", {22'b0, mem_address}, 32'd0);
      end
    end
  end

  // Monitor: every readdatavalid must match the oldest expected read, one cycle after its grant
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_waitrequest", {30'b0, s0_waitrequest, s1_waitrequest}, 32'd3);
      chk("rst_valid", {30'b0, s0_readdatavalid, s1_readdatavalid}, 32'd0);
      chk("rst_chipselect", {31'b0, mem_chipselect}, 32'd0);
    end else begin
      chk("valid_exclusive", {31'b0, s0_readdatavalid & s1_readdatavalid}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        bit v, e;
        logic [31:0] rdat;
        v = p ? s1_readdatavalid : s0_readdatavalid;
        rdat = p ? s1_readdata : s0_readdata;
        while (q[p].size() > 0 && q[p][0].c < cyc - 1) void'(q[p].pop_front());
        e = q[p].size() > 0 && q[p][0].c == cyc - 1;
        chk(p ? "s1_readdatavalid" : "s0_readdatavalid", {31'b0, v}, {31'b0, e});
        if (v && e) chk(p ? "s1_readdata" : "s0_readdata", rdat, q[p].pop_front().d);
      end
    end
  end

  function automatic bit wreq(input int p);
    return p ? s1_waitrequest : s0_waitrequest;
  endfunction

  task automatic drv(input int p, input bit rd, input bit wr, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = d;
    end else begin
      s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the command
  task automatic cmd(input int p, input bit rd, input bit wr, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    drv(p, rd, wr, a, be, d);
    @(negedge clk);
    while (wreq(p) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (wreq(p)) chk(p ? "s1_accept_timeout" : "s0_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 drv(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rnd_stream(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [9:0] a;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1008, 1023));
      cmd(p, k < 5 || k == 9, k >= 5, a, 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cmd(0, 1'b1, 1'b0, 10'h005, 4'hF, '0);
    cmd(0, 1'b0, 1'b1, 10'h3FF, 4'b0011, 32'hDEADBEEF);
    cmd(0, 1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    rst_pulse();
    start = cyc;
    fork
      for (int i = 0; i < 8; i++) cmd(0, 1'b1, 1'b0, 10'h001, 4'hF, '0);
      for (int i = 0; i < 8; i++) cmd(1, 1'b1, 1'b0, 10'h002, 4'hF, '0);
    join
    chk("conflict_cycles", cyc - start, 32'd17);
    start = cyc;
    for (int i = 0; i < 16; i++) cmd(1, 1'b1, 1'b0, 10'(i), 4'hF, '0);
    chk("s1_stream_cycles", cyc - start, 32'd16);
    cmd(0, 1'b1, 1'b0, 10'h007, 4'hF, '0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, s0_readdatavalid}, 32'd0);
    chk("async_rst_wait", {30'b0, s0_waitrequest, s1_waitrequest}, 32'd3);
    chk("async_rst_cs", {30'b0, mem_chipselect, mem_write}, 32'd0);
    chk("async_rst_addr", {22'b0, mem_address}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    fork
      rnd_stream(0, 300);
      rnd_stream(1, 300);
    join
`ifdef ONCHIP_ARB_STATS_EN
    rst_pulse();
    drv(0, 1'b1, 1'b0, 10'h004, 4'hF, '0);
    repeat (70002) @(posedge clk);
    #1 drv(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("stat_grant0", {16'b0, stat_grant0}, 32'h0000FFFF);
    chk("stat_grant1", {16'b0, stat_grant1}, 32'd0);
    chk("stat_conflict", {16'b0, stat_conflict}, 32'd0);
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("s0_outstanding", q[0].size(), 32'd0);
    chk("s1_outstanding", q[1].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
